// File: rtl/glyph_pixel_gen.sv
// Text-mode pixel generator: turns VGA timing counters into per-pixel colour from
// per-cell glyph bitmaps delivered over a valid/ready stream with a one-deep prefetch buffer.
module glyph_pixel_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int GLYPH_W  = 8,
  parameter int GLYPH_H  = 12,
  parameter int COLOR_W  = 4,
  parameter int COL_W    = $clog2(H_ACTIVE / GLYPH_W),
  parameter int ROW_W    = $clog2(V_ACTIVE / GLYPH_H)
) (
  input  logic                       clock25,
  input  logic                       reset_n,
  input  logic [9:0]                 HorizontalCounter,
  input  logic [9:0]                 VerticalCounter,
  input  logic [GLYPH_W*GLYPH_H-1:0] glyph_data,
  input  logic                       glyph_valid,
  output logic                       glyph_ready,
  output logic [COL_W-1:0]           NextCol,
  output logic [ROW_W-1:0]           NextRow,
  input  logic [COLOR_W-1:0]         fg_color,
  input  logic [COLOR_W-1:0]         bg_color,
  input  logic                       invert,
  input  logic                       clear_underrun,
  output logic [COLOR_W-1:0]         Pixel,
  output logic                       pixel_on,
  output logic                       underrun
);

  localparam int GBITS  = GLYPH_W * GLYPH_H;
  localparam int N_COLS = H_ACTIVE / GLYPH_W;
  localparam int PIX_W  = $clog2(GLYPH_W);
  localparam int L_W    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

  localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]       GW       = 10'(GLYPH_W);
  localparam logic [9:0]       GH       = 10'(GLYPH_H);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

  logic [9:0]         h_mod, v_mod;
  logic               active, cell_start, resync, xfer, underrun_set;
  logic               buf_full;
  logic [GBITS-1:0]   buf_data, src_glyph;
  logic [GLYPH_W-1:0] glyph_lines [GLYPH_H];
  logic [GLYPH_W-1:0] src_line, active_line;
  logic               cur_bit;

  logic               s1_active, s1_invert;
  logic [PIX_W-1:0]   s1_pix;
  logic [COLOR_W-1:0] s1_fg, s1_bg;

  assign glyph_ready = !buf_full;

  always_comb begin
    h_mod        = HorizontalCounter % GW;
    v_mod        = VerticalCounter % GH;
    active       = (HorizontalCounter < H_ACT) && (VerticalCounter < V_ACT);
    cell_start   = active && (h_mod == '0);
    resync       = (VerticalCounter == V_ACT) && (HorizontalCounter == '0);
    xfer         = glyph_valid && !buf_full;
    underrun_set = cell_start && !buf_full && !glyph_valid;
    // Buffered glyph has priority; an empty buffer falls through to the live stream.
    src_glyph    = buf_full ? buf_data : (glyph_valid ? glyph_data : '0);
    for (int unsigned i = 0; i < GLYPH_H; i++)
      glyph_lines[i] = src_glyph[GBITS-1-i*GLYPH_W -: GLYPH_W];
    src_line     = glyph_lines[L_W'(v_mod)];
    cur_bit      = active_line[PIX_W'(GLYPH_W-1) - s1_pix];
  end

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      NextCol  <= '0;
      NextRow  <= '0;
    end else if (resync) begin
      buf_full <= 1'b0;
      NextCol  <= '0;
      NextRow  <= '0;
    end else if (cell_start) begin
      buf_full <= 1'b0;
      if (NextCol == LAST_COL) begin
        NextCol <= '0;
        // Row pointer steps only when the line just finished was the glyph's last line.
        if (VerticalCounter == V_ACT - 10'd1)
          NextRow <= '0;
        else if (v_mod == GH - 10'd1)
          NextRow <= NextRow + ROW_W'(1);
      end else begin
        NextCol <= NextCol + COL_W'(1);
      end
    end else if (xfer) begin
      buf_full <= 1'b1;
      buf_data <= glyph_data;
    end
  end

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      active_line <= '0;
      underrun    <= 1'b0;
      s1_active   <= 1'b0;
      s1_pix      <= '0;
      s1_invert   <= 1'b0;
      s1_fg       <= '0;
      s1_bg       <= '0;
      Pixel       <= '0;
      pixel_on    <= 1'b0;
    end else begin
      if (cell_start)
        active_line <= src_line;
      if (underrun_set)
        underrun <= 1'b1;
      else if (clear_underrun)
        underrun <= 1'b0;
      s1_active <= active;
      s1_pix    <= PIX_W'(h_mod);
      s1_invert <= invert;
      s1_fg     <= fg_color;
      s1_bg     <= bg_color;
      pixel_on  <= s1_active && cur_bit;
      if (!s1_active)
        Pixel <= '0;
      else
        Pixel <= (cur_bit ^ s1_invert) ? s1_fg : s1_bg;
    end
  end

endmodule

// File: tb/tb_glyph_pixel_gen.sv
// Bench for glyph_pixel_gen: directed scenarios plus randomized scanlines checked
// against a queue-based reference of the glyph stream and pixel colour rules.
module tb_glyph_pixel_gen;
  localparam int GW = 8;
  localparam int GH = 12;
  localparam int GB = GW * GH;

  logic          clock25 = 1'b0;
  logic          reset_n;
  logic [9:0]    HorizontalCounter, VerticalCounter;
  logic [GB-1:0] glyph_data;
  logic          glyph_valid, glyph_ready;
  logic [6:0]    NextCol;
  logic [5:0]    NextRow;
  logic [3:0]    fg_color, bg_color, Pixel;
  logic          invert, clear_underrun, pixel_on, underrun;

  glyph_pixel_gen #(
    .H_ACTIVE(640), .V_ACTIVE(480), .GLYPH_W(GW), .GLYPH_H(GH), .COLOR_W(4)
  ) dut (
    .clock25(clock25), .reset_n(reset_n),
    .HorizontalCounter(HorizontalCounter), .VerticalCounter(VerticalCounter),
    .glyph_data(glyph_data), .glyph_valid(glyph_valid), .glyph_ready(glyph_ready),
    .NextCol(NextCol), .NextRow(NextRow),
    .fg_color(fg_color), .bg_color(bg_color), .invert(invert),
    .clear_underrun(clear_underrun),
    .Pixel(Pixel), .pixel_on(pixel_on), .underrun(underrun)
  );

  always #20 clock25 = ~clock25;

  int tests = 0;
  int fails = 0;

  // Reference state: the prefetch buffer is a queue of whole glyphs.
  logic [GB-1:0] m_q[$];
  int            m_nc, m_nr, m_L;
  bit            m_under;
  logic [GB-1:0] m_glyph;
  logic [3:0]    m_pix_s1, m_pix_out;
  bit            m_on_s1, m_on_out;
  logic [3:0]    last_pix;

  logic [GB-1:0] a5g = {8'hA5, 88'h3C_81_7E_00_FF_18_24_42_99_66_C3};
  logic [3:0]    exp_a5  [8] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF};
  logic [3:0]    exp_a5i [8] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [GB-1:0] rglyph();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_nc = 0; m_nr = 0; m_L = 0; m_under = 0; m_glyph = '0;
    m_pix_s1 = '0; m_pix_out = '0; m_on_s1 = 0; m_on_out = 0;
  endtask

  task automatic check_outputs();
    chk("glyph_ready", 32'(glyph_ready), 32'(m_q.size() == 0));
    chk("NextCol",     32'(NextCol),     32'(m_nc));
    chk("NextRow",     32'(NextRow),     32'(m_nr));
    chk("Pixel",       32'(Pixel),       32'(m_pix_out));
    chk("pixel_on",    32'(pixel_on),    32'(m_on_out));
    chk("underrun",    32'(underrun),    32'(m_under));
    last_pix = Pixel;
  endtask

  // One pixel-clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic step(input int h, input int v, input bit valid, input logic [GB-1:0] data,
                      input bit inv, input logic [3:0] fg, input logic [3:0] bg, input bit clr);
    bit active, cstart, empty, b;
    logic [GB-1:0] g;
    logic [3:0] p;
    HorizontalCounter = h[9:0]; VerticalCounter = v[9:0];
    glyph_valid = valid; glyph_data = data; invert = inv;
    fg_color = fg; bg_color = bg; clear_underrun = clr;
    @(negedge clock25);
    check_outputs();
    active = (h < 640) && (v < 480);
    cstart = active && (h % GW == 0);
    empty  = (m_q.size() == 0);
    if (cstart) begin
      if (!empty)     g = m_q.pop_front();
      else if (valid) g = data;
      else            g = '0;
      m_glyph = g;
      m_L = v % GH;
      if (m_nc == 79) begin
        m_nc = 0;
        m_nr = (v + 1 == 480) ? 0 : (v + 1) / GH;
      end else begin
        m_nc++;
      end
    end else if (valid && empty) begin
      m_q.push_back(data);
    end
    if (v == 480 && h == 0) begin
      m_q.delete(); m_nc = 0; m_nr = 0;
    end
    if (cstart && empty && !valid) m_under = 1;
    else if (clr)                  m_under = 0;
    if (active) begin
      b = m_glyph[GB - 1 - m_L * GW - (h % GW)];
      p = (b ^ inv) ? fg : bg;
    end else begin
      b = 0; p = '0;
    end
    m_pix_out = m_pix_s1; m_on_out = m_on_s1;
    m_pix_s1 = p;         m_on_s1 = b;
    @(posedge clock25); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_Pixel",    32'(Pixel),       32'h0);
    chk("rst_pixel_on", 32'(pixel_on),    32'h0);
    chk("rst_underrun", 32'(underrun),    32'h0);
    chk("rst_ready",    32'(glyph_ready), 32'h1);
    chk("rst_NextCol",  32'(NextCol),     32'h0);
    chk("rst_NextRow",  32'(NextRow),     32'h0);
    HorizontalCounter = 10'd700; VerticalCounter = 10'd0;
    glyph_valid = 1'b0; glyph_data = '0; invert = 1'b0;
    fg_color = '0; bg_color = '0; clear_underrun = 1'b0;
    m_reset();
    @(negedge clock25);
    reset_n = 1'b1;
    @(posedge clock25); #1;
  endtask

  task automatic rline(input int v, input int prob);
    for (int h = 0; h < 660; h++)
      step(h, v, $urandom_range(99) < prob, rglyph(), bit'($urandom_range(1)),
           4'($urandom), 4'($urandom), $urandom_range(63) == 0);
  endtask

  initial begin
    reset_n = 1'b1;
    HorizontalCounter = 10'd700; VerticalCounter = '0;
    glyph_valid = 1'b0; glyph_data = '0; invert = 1'b0;
    fg_color = '0; bg_color = '0; clear_underrun = 1'b0;
    m_reset();
    @(posedge clock25); #1;

    // Line 0 of glyph A5, then a starved cell at H=16.
    do_reset();
    for (int h = 0; h < 660; h++) begin
      step(h, 0, !(h >= 9 && h <= 16), a5g, 1'b0, 4'hF, (h < 10) ? 4'h0 : 4'h5, 1'b0);
      if (h >= 2 && h <= 9)   chk("a5_pix", 32'(last_pix), 32'(exp_a5[h-2]));
      if (h >= 18 && h <= 25) chk("underrun_bg_pix", 32'(last_pix), 32'h5);
      if (h == 8)  chk("no_underrun_yet", 32'(underrun), 32'h0);
      if (h == 20) chk("underrun_set", 32'(underrun), 32'h1);
    end
    chk("underrun_sticky", 32'(underrun), 32'h1);
    for (int h = 0; h < 12; h++) begin
      step(h, 1, 1'b0, rglyph(), 1'b0, 4'hC, 4'h3, h == 8 || h == 10);
      if (h == 9)  chk("underrun_set_and_clear", 32'(underrun), 32'h1);
      if (h == 11) chk("underrun_cleared", 32'(underrun), 32'h0);
    end

    // Same glyph with invert held high.
    do_reset();
    for (int h = 0; h < 10; h++) begin
      step(h, 0, 1'b1, a5g, 1'b1, 4'hF, 4'h0, 1'b0);
      if (h >= 2) chk("a5_inv_pix", 32'(last_pix), 32'(exp_a5i[h-2]));
    end

    // Random traffic over the first text rows.
    do_reset();
    for (int v = 0; v < 13; v++) begin
      rline(v, 75);
      if (v == 11) begin
        chk("row_wrap_col", 32'(NextCol), 32'h0);
        chk("row_wrap_row", 32'(NextRow), 32'h1);
      end
    end

    // Last active line, then resync with a full buffer.
    rline(479, 75);
    chk("frame_wrap_col", 32'(NextCol), 32'h0);
    chk("frame_wrap_row", 32'(NextRow), 32'h0);
    step(660, 479, 1'b1, rglyph(), 1'b0, 4'h1, 4'h2, 1'b0);
    step(661, 479, 1'b0, rglyph(), 1'b0, 4'h1, 4'h2, 1'b0);
    chk("stale_full", 32'(glyph_ready), 32'h0);
    step(0, 480, 1'b0, rglyph(), 1'b0, 4'h1, 4'h2, 1'b0);
    chk("resync_ready", 32'(glyph_ready), 32'h1);
    chk("resync_col",   32'(NextCol),     32'h0);
    chk("resync_row",   32'(NextRow),     32'h0);

    // Blanking regions only.
    for (int i = 0; i < 60; i++) begin
      int h, v;
      if (i % 2 == 0) begin h = $urandom_range(799, 640); v = $urandom_range(479); end
      else            begin h = $urandom_range(799);      v = $urandom_range(524, 481); end
      step(h, v, bit'($urandom_range(1)), rglyph(), bit'($urandom_range(1)),
           4'($urandom), 4'($urandom), 1'b0);
    end
    chk("blank_Pixel",    32'(Pixel),    32'h0);
    chk("blank_pixel_on", 32'(pixel_on), 32'h0);
    step(0, 480, 1'b0, rglyph(), 1'b0, 4'h0, 4'h0, 1'b0);

    // Reset in the middle of an active line, then resume.
    for (int h = 0; h < 300; h++)
      step(h, 0, $urandom_range(99) < 60, rglyph(), bit'($urandom_range(1)),
           4'($urandom), 4'($urandom), 1'b0);
    #5;
    do_reset();
    for (int v = 0; v < 2; v++) rline(v, 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
